// File: rtl/duty_button_conditioner.sv
// duty_button_conditioner
// Front end of the PWM duty-cycle generator. Each raw push button is
// synchronized, debounced and turned into one-cycle step requests. Holding a
// button auto-repeats. Holding both buttons locks both of them out.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   ena          pulse-output enable; 0 masks duty_inc/duty_dec, state keeps running
//   btn_inc_raw  raw asynchronous increase button
//   btn_dec_raw  raw asynchronous decrease button
//   duty_inc     registered one-cycle increase request
//   duty_dec     registered one-cycle decrease request
//   inc_level    registered debounced level of the increase button
//   dec_level    registered debounced level of the decrease button
module duty_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn_inc_raw,
  input  logic btn_dec_raw,
  output logic duty_inc,
  output logic duty_dec,
  output logic inc_level,
  output logic dec_level
);

  localparam int unsigned NCH    = 2;
  localparam int unsigned CH_INC = 0;
  localparam int unsigned CH_DEC = 1;

  // Terminal counts; guarded so a zero parameter never underflows.
  localparam int unsigned DB_LAST = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam int unsigned RD_LAST = (REPEAT_DELAY    > 0) ? REPEAT_DELAY    - 1 : 0;
  localparam int unsigned RP_LAST = (REPEAT_PERIOD   > 0) ? REPEAT_PERIOD   - 1 : 0;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS       = 2'd1,
    HOLD_DELAY  = 2'd2,
    HOLD_REPEAT = 2'd3
  } state_e;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   meta_q;
  logic [NCH-1:0]   sync_q;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] dcnt_q [NCH];
  logic [CNT_W-1:0] dcnt_d [NCH];
  logic [CNT_W-1:0] rcnt_q [NCH];
  logic [CNT_W-1:0] rcnt_d [NCH];
  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [NCH-1:0]   pulse_c;
  logic             lock_now;
  logic             lock_prev;

  assign raw = {btn_dec_raw, btn_inc_raw};

  // Two-flop synchronizer, debounced level and debounce counters.
  always_ff @(posedge clk or posedge rst) begin : sync_debounce_reg
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      dcnt_q[0] <= '0;
      dcnt_q[1] <= '0;
    end else begin
      meta_q    <= raw;
      sync_q    <= meta_q;
      stable_q  <= stable_d;
      dcnt_q[0] <= dcnt_d[0];
      dcnt_q[1] <= dcnt_d[1];
    end
  end

  // Debounce: count consecutive disagreeing samples; flip on the last one.
  always_comb begin : debounce_next
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      dcnt_d[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (dcnt_q[i] == CNT_W'(DB_LAST)) begin
          stable_d[i] = sync_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Per-channel press/repeat state machine with mutual lockout. Decisions use
  // the levels as they will be after this edge, so the press pulse lands on
  // the same edge as the debounced rise.
  always_comb begin : fsm_next
    lock_now  = &stable_d;
    lock_prev = &stable_q;
    pulse_c   = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (!stable_d[i]) begin
        state_d[i] = IDLE;
        rcnt_d[i]  = '0;
      end else if (lock_now) begin
        // Both held: park in HOLD_DELAY with the repeat counter frozen at 0.
        state_d[i] = HOLD_DELAY;
        rcnt_d[i]  = '0;
      end else if (!stable_q[i]) begin
        state_d[i] = PRESS;
        rcnt_d[i]  = '0;
        pulse_c[i] = 1'b1;
      end else if (lock_prev) begin
        // Other button just released: restart the delay, no pulse.
        state_d[i] = HOLD_DELAY;
        rcnt_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          // PRESS is the first cycle of the repeat delay, so it counts too.
          PRESS, HOLD_DELAY: begin
            state_d[i] = HOLD_DELAY;
            if (REPEAT_DELAY != 0) begin
              if (rcnt_q[i] == CNT_W'(RD_LAST)) begin
                state_d[i] = HOLD_REPEAT;
                rcnt_d[i]  = '0;
                pulse_c[i] = 1'b1;
              end else begin
                rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
              end
            end
          end
          HOLD_REPEAT: begin
            if (rcnt_q[i] == CNT_W'(RP_LAST)) begin
              rcnt_d[i]  = '0;
              pulse_c[i] = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + CNT_W'(1);
            end
          end
          default: begin
            state_d[i] = state_q[i];
          end
        endcase
      end
    end
  end

  // State, repeat counters and registered step requests.
  always_ff @(posedge clk or posedge rst) begin : fsm_reg
    if (rst) begin
      state_q[0] <= IDLE;
      state_q[1] <= IDLE;
      rcnt_q[0]  <= '0;
      rcnt_q[1]  <= '0;
      duty_inc   <= 1'b0;
      duty_dec   <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      rcnt_q[0]  <= rcnt_d[0];
      rcnt_q[1]  <= rcnt_d[1];
      duty_inc   <= ena & pulse_c[CH_INC];
      duty_dec   <= ena & pulse_c[CH_DEC];
    end
  end

  assign inc_level = stable_q[CH_INC];
  assign dec_level = stable_q[CH_DEC];

endmodule

// File: tb/tb_duty_button_conditioner.sv
// Bench for duty_button_conditioner: directed test-plan scenarios plus random
// button activity, all checked against a behavioural model via a scoreboard.
module tb_duty_button_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;
  localparam int CW  = 24;

  logic clk;
  logic rst;
  logic ena;
  logic btn_inc_raw;
  logic btn_dec_raw;
  logic duty_inc;
  logic duty_dec;
  logic inc_level;
  logic dec_level;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;
  int e;

  logic [3:0] exp_q[$];
  logic [3:0] mon_exp;
  logic [3:0] mon_act;
  int         inc_edges[$];
  int         dec_edges[$];

  // Reference model state
  bit [1:0] m_meta, m_sync, m_stable, m_new, m_pulse;
  int       m_run[2];
  int       m_anchor[2];
  bit       m_active[2];
  bit       m_lock_now, m_lock_prev;
  int       m_k;

  // Random stimulus state
  int rem[2];
  bit lvl[2];

  duty_button_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP),
    .CNT_W          (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .btn_inc_raw(btn_inc_raw),
    .btn_dec_raw(btn_dec_raw),
    .duty_inc   (duty_inc),
    .duty_dec   (duty_dec),
    .inc_level  (inc_level),
    .dec_level  (dec_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int outs();
    return int'({duty_inc, duty_dec, inc_level, dec_level});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_count(input string name, input bit dec_ch, input int exp);
    check(name, dec_ch ? dec_edges.size() : inc_edges.size(), exp);
  endtask

  task automatic check_nth(input string name, input bit dec_ch, input int n, input int exp);
    int act;
    if (dec_ch) act = (n < dec_edges.size()) ? dec_edges[n] : -1;
    else        act = (n < inc_edges.size()) ? inc_edges[n] : -1;
    check(name, act, exp);
  endtask

  task automatic clear_log();
    inc_edges.delete();
    dec_edges.delete();
  endtask

  // Advance n clocks; inputs are always changed just after a falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Behavioural model: run-length debounce over a 2-edge delayed input, then
  // pulses at fixed offsets from an anchor edge (press or lockout release).
  always @(posedge clk) begin
    edge_cnt++;
    if (rst) begin
      m_meta   = '0;
      m_sync   = '0;
      m_stable = '0;
      for (int ch = 0; ch < 2; ch++) begin
        m_run[ch]    = 0;
        m_anchor[ch] = 0;
        m_active[ch] = 1'b0;
      end
      exp_q.push_back(4'b0000);
    end else begin
      m_new = m_stable;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_sync[ch] != m_stable[ch]) begin
          m_run[ch]++;
          if (m_run[ch] == DEB) begin
            m_new[ch] = m_sync[ch];
            m_run[ch] = 0;
          end
        end else begin
          m_run[ch] = 0;
        end
      end
      m_sync      = m_meta;
      m_meta      = {btn_dec_raw, btn_inc_raw};
      m_lock_now  = m_new[0] & m_new[1];
      m_lock_prev = m_stable[0] & m_stable[1];
      m_pulse     = '0;
      for (int ch = 0; ch < 2; ch++) begin
        if (!m_new[ch] || m_lock_now) begin
          m_active[ch] = 1'b0;
        end else if (!m_stable[ch]) begin
          m_anchor[ch] = edge_cnt;
          m_active[ch] = 1'b1;
          m_pulse[ch]  = 1'b1;
        end else if (m_lock_prev) begin
          m_anchor[ch] = edge_cnt;
          m_active[ch] = 1'b1;
        end else if (m_active[ch] && RD != 0) begin
          m_k = edge_cnt - m_anchor[ch];
          if (m_k >= RD && ((m_k - RD) % RP) == 0) m_pulse[ch] = 1'b1;
        end
      end
      m_stable = m_new;
      exp_q.push_back({m_pulse[0] & ena, m_pulse[1] & ena, m_new[0], m_new[1]});
    end
  end

  // Monitor: compare every presented output cycle against the scoreboard.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {duty_inc, duty_dec, inc_level, dec_level};
      checks++;
      if (mon_act !== mon_exp) begin
        failures++;
        $display("FAIL scoreboard edge %0d: got %b expected %b (inc,dec,inc_lvl,dec_lvl)",
                 edge_cnt, mon_act, mon_exp);
      end
      checks++;
      if (duty_inc === 1'b1 && duty_dec === 1'b1) begin
        failures++;
        $display("FAIL exclusive edge %0d: got both pulses expected at most one", edge_cnt);
      end
    end
    if (duty_inc === 1'b1) inc_edges.push_back(edge_cnt);
    if (duty_dec === 1'b1) dec_edges.push_back(edge_cnt);
  end

  initial begin
    rst = 1'b1; ena = 1'b1; btn_inc_raw = 1'b0; btn_dec_raw = 1'b0;
    cyc(3);
    check("reset_outputs", outs(), 0);
    rst = 1'b0;
    cyc(5);

    // Clean press: one pulse 6 edges after the rise, none on release.
    clear_log();
    e = edge_cnt; btn_inc_raw = 1'b1; cyc(10);
    btn_inc_raw = 1'b0; cyc(15);
    check_count("clean_inc_count", 1'b0, 1);
    check_nth("clean_inc_edge", 1'b0, 0, e + 6);
    check_count("clean_dec_none", 1'b1, 0);

    // Bounce on dec, then a stable hold.
    clear_log();
    btn_dec_raw = 1'b1; cyc(2);
    btn_dec_raw = 1'b0; cyc(1);
    btn_dec_raw = 1'b1; cyc(3);
    btn_dec_raw = 1'b0; cyc(2);
    e = edge_cnt; btn_dec_raw = 1'b1; cyc(12);
    btn_dec_raw = 1'b0; cyc(15);
    check_count("bounce_dec_count", 1'b1, 1);
    check_nth("bounce_dec_edge", 1'b1, 0, e + 6);
    check_count("bounce_inc_none", 1'b0, 0);

    // Auto-repeat: P, P+20, then every 8.
    clear_log();
    e = edge_cnt; btn_inc_raw = 1'b1; cyc(67);
    btn_inc_raw = 1'b0; cyc(15);
    check_count("repeat_count", 1'b0, 7);
    for (int i = 0; i < 7; i++)
      check_nth($sformatf("repeat_edge%0d", i), 1'b0, i, (i == 0) ? e + 6 : e + 6 + RD + RP * (i - 1));

    // Lockout: simultaneous press, release dec; inc restarts its delay.
    clear_log();
    e = edge_cnt; btn_inc_raw = 1'b1; btn_dec_raw = 1'b1; cyc(40);
    btn_dec_raw = 1'b0; cyc(30);
    btn_inc_raw = 1'b0; cyc(15);
    check_count("lockout_dec_none", 1'b1, 0);
    check_nth("lockout_inc_first", 1'b0, 0, e + 46 + RD);
    check_count("lockout_inc_count", 1'b0, 2);

    // Enable masks the press pulse; next pulse follows the repeat schedule.
    clear_log();
    e = edge_cnt; ena = 1'b0; btn_inc_raw = 1'b1; cyc(10);
    ena = 1'b1; cyc(20);
    btn_inc_raw = 1'b0; cyc(15);
    check_nth("enable_first", 1'b0, 0, e + 6 + RD);
    check_count("enable_count", 1'b0, 2);

    // Reset mid-hold clears everything at once; press re-detected afterwards.
    btn_inc_raw = 1'b1; cyc(10);
    check("pre_reset_level", int'(inc_level), 1);
    rst = 1'b1; #1;
    check("reset_async", outs(), 0);
    clear_log();
    cyc(3);
    e = edge_cnt; rst = 1'b0; cyc(12);
    btn_inc_raw = 1'b0; cyc(15);
    check_nth("reset_repress_edge", 1'b0, 0, e + 6);
    check_count("reset_repress_count", 1'b0, 1);

    // Random activity: bounces, holds long enough to repeat, overlaps.
    for (int ch = 0; ch < 2; ch++) begin
      rem[ch] = 0;
      lvl[ch] = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = int'($urandom_range(1, 60));
        end
        rem[ch]--;
      end
      btn_inc_raw = lvl[0];
      btn_dec_raw = lvl[1];
      ena = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    rst = 1'b0; btn_inc_raw = 1'b0; btn_dec_raw = 1'b0; ena = 1'b1;
    cyc(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
